instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Instruction fetch stage: owns the program counter, drives the synchronous instruction memory, and produces the IF/ID pipeline register.
- Consumes `pc_write`/`if_id_write` from the load-use hazard logic and the taken-branch redirect from the execute stage.
- Contains a one-entry skid buffer, so the instruction returned during a stall is never lost.
- Sits directly upstream of decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written on flush/reset

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- pc_write  in  1  0 = hold PC (load-use stall)
- if_id_write  in  1  0 = hold IF/ID register; always driven equal to pc_write
- branch_taken  in  1  redirect request from EX
- branch_target  in  32  redirect PC, word aligned
- imem_addr  out  32  instruction memory address = pc_reg
- imem_rdata  in  32  instruction memory data, valid one cycle after address
- pc_IF_ID  out  32  PC of instruction in IF/ID
- instr_IF_ID  out  32  instruction in IF/ID
- valid_IF_ID  out  1  IF/ID holds a real instruction
- stall_cnt  out  32  only with STALL_COUNTER_EN
- flush_cnt  out  32  only with STALL_COUNTER_EN

## Operation
- Registers:
  - pc_reg: next fetch address.
  - pc_d1: address whose data is on imem_rdata this cycle.
  - skid / skid_pc: held instruction.
  - state.
- States:
  - BOOT: after reset; arriving data invalid.
  - RUN: arriving data valid for pc_d1.
  - HOLD: stalled; the instruction is in skid.
  - DROP: one cycle after a redirect; arriving data is wrong-path.
- Priority per edge: branch_taken > stall > normal advance.
- Redirect (branch_taken=1, any state):
  - pc_reg <= branch_target.
  - IF/ID <= {0, NOP_INSTR, valid 0}.
  - skid discarded; state -> DROP.
  - Stall inputs are ignored that edge.
- Stall (if_id_write=0, no redirect):
  - pc_reg, pc_d1 and IF/ID hold.
  - RUN: skid <= imem_rdata, state -> HOLD.
  - HOLD, BOOT, DROP: no change.
- Advance (if_id_write=1, no redirect):
  - pc_reg <= pc_reg+4, pc_d1 <= pc_reg.
  - RUN: IF/ID <= {pc_d1, imem_rdata, 1}.
  - HOLD: IF/ID <= {pc_d1, skid, 1}, state -> RUN.
  - BOOT/DROP: IF/ID <= {0, NOP_INSTR, 0}, state -> RUN.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. No alignment check.
- pc_write != if_id_write is unsupported; the bench asserts equality.

## Timing
- Reset (asynchronous, immediate):
  - pc_reg=RESET_PC, pc_d1=0, state=BOOT.
  - pc_IF_ID=0, instr_IF_ID=NOP_INSTR, valid_IF_ID=0.
  - skid=0, counters=0.
- First valid IF/ID: after the 2nd rising edge following reset release, absent stalls.
- Fetch-to-IF/ID latency: 2 edges.
- Throughput: 1 instruction/cycle.
- Branch penalty: a redirect at edge N gives bubbles at N and N+1. Target instruction is in IF/ID after edge N+2.
- Stall of k cycles: IF/ID frozen k cycles. The same instruction stream then resumes with no duplicate or loss.
- Reset asserted mid-stall or mid-DROP: returns to the reset values; skid content is lost.
- imem_addr is purely registered (pc_reg); there is no combinational path from inputs.

## Configuration
- STALL_COUNTER_EN defined:
  - stall_cnt increments on every edge with if_id_write=0 and branch_taken=0.
  - flush_cnt increments on every edge with branch_taken=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package (fetch_pkg):
  - fetch_state_t enum {BOOT, RUN, HOLD, DROP}.
  - NOP_INSTR constant.
  - Default RESET_PC constant.
- Sub-module fetch_skid_buffer: skid + skid_pc with load/clear, reset to 0.
- The PC and IF/ID registers stay in the top module.

## Test plan
- Reset release, imem returns mem[a]=a^32'hA5A5_0000, no stalls -> after edge 2: pc_IF_ID=0, instr=32'hA5A5_0000, valid=1. Edge 3: pc_IF_ID=4.
- Stall 3 cycles while in RUN with pc_IF_ID=8 -> IF/ID holds 8 for 3 cycles, then 12, 16 in order with no skip or duplicate.
- branch_taken at PC 0x10 with target 0x100 -> two bubbles (valid=0, instr=0x13), then pc_IF_ID=0x100. flush_cnt=1 with the macro.
- branch_taken and if_id_write=0 on the same edge in HOLD -> redirect wins, skid dropped, target appears after 2 more edges.
- RESET_PC=32'hFFFF_FFF8, run 4 cycles -> pc_IF_ID sequence FFFF_FFF8, FFFF_FFFC, 0, 4.
- Assert arst_n low during HOLD -> outputs immediately at reset values. Restart from RESET_PC; stall_cnt=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Definitions shared by the instruction fetch stage and its skid buffer:
//   fetch_state_t     - fetch FSM state encoding (BOOT, RUN, HOLD, DROP)
//   NOP_INSTR         - bubble encoding (addi x0,x0,0) written on flush/reset
//   DEFAULT_RESET_PC  - default program counter after reset
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_pkg;

    // BOOT : out of reset, the data arriving from imem is not a real fetch.
    // RUN  : the data arriving from imem is the instruction at pc_d1.
    // HOLD : stalled; the instruction captured at the stall sits in the skid.
    // DROP : one cycle after a redirect; the data arriving is wrong-path.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for the instruction (and its PC) that returns
// from instruction memory in the cycle a stall begins, so it is not lost.
// Ports:
//   clk       in   clock, rising edge
//   arst_n    in   asynchronous active-low reset (contents cleared to 0)
//   i_load    in   capture i_instr / i_pc on this edge
//   i_clear   in   discard the held entry (wins over i_load)
//   i_instr   in   instruction to capture
//   i_pc      in   PC of the instruction to capture
//   o_instr   out  held instruction
//   o_pc      out  PC of the held instruction
// ---------------------------------------------------------------------------
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_instr <= 32'h0;
            r_pc    <= 32'h0;
        end else if (i_clear) begin
            r_instr <= 32'h0;
            r_pc    <= 32'h0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : fetch_skid_buffer

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
// Owns the program counter, addresses the synchronous instruction memory
// (data returns one cycle after the address) and produces the IF/ID register.
// Edge priority: branch redirect > stall > normal advance.
// Optional feature: define STALL_COUNTER_EN to add stall_cnt / flush_cnt.
// Parameters:
//   RESET_PC    PC loaded on reset
//   NOP_INSTR   bubble encoding written on flush/reset
// Ports:
//   clk            in   clock, rising edge
//   arst_n         in   asynchronous active-low reset
//   pc_write       in   0 = hold PC (load-use stall)
//   if_id_write    in   0 = hold IF/ID (driven equal to pc_write)
//   branch_taken   in   redirect request from EX
//   branch_target  in   redirect PC, word aligned
//   imem_addr      out  instruction memory address (= pc_reg, registered)
//   imem_rdata     in   instruction memory data, one cycle after address
//   pc_IF_ID       out  PC of instruction in IF/ID
//   instr_IF_ID    out  instruction in IF/ID
//   valid_IF_ID    out  IF/ID holds a real instruction
//   stall_cnt      out  stall edges counted (STALL_COUNTER_EN only)
//   flush_cnt      out  redirect edges counted (STALL_COUNTER_EN only)
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_IF_ID,
    output logic [31:0] instr_IF_ID,
    output logic        valid_IF_ID
`ifdef STALL_COUNTER_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    import fetch_pkg::*;

    fetch_state_t r_state;
    logic [31:0]  r_pc;          // next fetch address
    logic [31:0]  r_pc_d1;       // address whose data is on imem_rdata now
    logic [31:0]  r_pc_ifid;
    logic [31:0]  r_instr_ifid;
    logic         r_valid_ifid;

    logic         w_skid_load;
    logic         w_skid_clear;
    logic [31:0]  w_skid_instr;
    logic [31:0]  w_skid_pc;

    // Only a stall that starts in RUN has a live instruction to rescue; in
    // BOOT/DROP the arriving data is junk and in HOLD the skid is already full.
    assign w_skid_load  = !branch_taken && !if_id_write && (r_state == RUN);
    assign w_skid_clear = branch_taken;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (imem_rdata),
        .i_pc    (r_pc_d1),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_pc_d1      <= 32'h0;
            r_pc_ifid    <= 32'h0;
            r_instr_ifid <= NOP_INSTR;
            r_valid_ifid <= 1'b0;
        end else if (branch_taken) begin
            // Redirect: the in-flight fetch is wrong-path, so DROP throws away
            // the data that arrives next cycle.
            r_pc         <= branch_target;
            r_pc_ifid    <= 32'h0;
            r_instr_ifid <= NOP_INSTR;
            r_valid_ifid <= 1'b0;
            r_state      <= DROP;
        end else begin
            // PC wraps modulo 2^32 through the natural 32-bit add.
            if (pc_write) begin
                r_pc    <= r_pc + 32'd4;
                r_pc_d1 <= r_pc;
            end

            if (if_id_write) begin
                case (r_state)
                    RUN: begin
                        r_pc_ifid    <= r_pc_d1;
                        r_instr_ifid <= imem_rdata;
                        r_valid_ifid <= 1'b1;
                    end
                    HOLD: begin
                        // The skid holds the instruction that was on the bus
                        // when the stall began; imem has since moved on.
                        r_pc_ifid    <= w_skid_pc;
                        r_instr_ifid <= w_skid_instr;
                        r_valid_ifid <= 1'b1;
                        r_state      <= RUN;
                    end
                    default: begin
                        r_pc_ifid    <= 32'h0;
                        r_instr_ifid <= NOP_INSTR;
                        r_valid_ifid <= 1'b0;
                        r_state      <= RUN;
                    end
                endcase
            end else if (r_state == RUN) begin
                r_state <= HOLD;
            end
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else if (branch_taken) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
        end else if (!if_id_write) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

    assign imem_addr   = r_pc;
    assign pc_IF_ID    = r_pc_ifid;
    assign instr_IF_ID = r_instr_ifid;
    assign valid_IF_ID = r_valid_ifid;

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage
// Self-checking bench for instruction_fetch_stage. A synchronous memory model
// returns mem[a] = a ^ 32'hA5A5_0000 one cycle after the address. A second
// instance with RESET_PC = 32'hFFFF_FFF8 covers PC wrap-around.
// Counter checks are compiled in when STALL_COUNTER_EN is defined.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        arst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IF_ID;
    logic [31:0] instr_IF_ID;
    logic        valid_IF_ID;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    // Second instance: free-running, never stalled or redirected.
    logic        w2_pc_write;
    logic        w2_branch_taken;
    logic [31:0] w2_branch_target;
    logic [31:0] w2_imem_addr;
    logic [31:0] w2_imem_rdata;
    logic [31:0] w2_pc_IF_ID;
    logic [31:0] w2_instr_IF_ID;
    logic        w2_valid_IF_ID;
`ifdef STALL_COUNTER_EN
    logic [31:0] w2_stall_cnt;
    logic [31:0] w2_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    instruction_fetch_stage dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pc_IF_ID      (pc_IF_ID),
        .instr_IF_ID   (instr_IF_ID),
        .valid_IF_ID   (valid_IF_ID)
`ifdef STALL_COUNTER_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    instruction_fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk           (clk),
        .arst_n        (arst_n),
        .pc_write      (w2_pc_write),
        .if_id_write   (w2_pc_write),
        .branch_taken  (w2_branch_taken),
        .branch_target (w2_branch_target),
        .imem_addr     (w2_imem_addr),
        .imem_rdata    (w2_imem_rdata),
        .pc_IF_ID      (w2_pc_IF_ID),
        .instr_IF_ID   (w2_instr_IF_ID),
        .valid_IF_ID   (w2_valid_IF_ID)
`ifdef STALL_COUNTER_EN
        ,
        .stall_cnt     (w2_stall_cnt),
        .flush_cnt     (w2_flush_cnt)
`endif
    );

    // Synchronous instruction memories.
    always @(posedge clk) begin
        imem_rdata    <= mem(imem_addr);
        w2_imem_rdata <= mem(w2_imem_addr);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (pc_write == if_id_write)
            else $error("pc_write and if_id_write differ");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        pw;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
    } vec_t;

    vec_t vecs[19];
    vec_t sb_q[$];
    logic [31:0] wrap_exp_pc[4];

    initial begin
        vec_t v;
        vec_t e;

        // {pw, br, tgt, IF/ID pc, instr, valid, imem_addr, stall_cnt, flush_cnt}
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   32'h0,   NOP,         1'b0, 32'h4,   32'd0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   32'h0,   mem(32'h0),  1'b1, 32'h8,   32'd0, 32'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,   32'h4,   mem(32'h4),  1'b1, 32'hC,   32'd0, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,   32'h8,   mem(32'h8),  1'b1, 32'h10,  32'd0, 32'd0};
        // 3-cycle stall with pc_IF_ID = 8
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   32'h8,   mem(32'h8),  1'b1, 32'h10,  32'd1, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'h8,   mem(32'h8),  1'b1, 32'h10,  32'd2, 32'd0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'h8,   mem(32'h8),  1'b1, 32'h10,  32'd3, 32'd0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,   32'hC,   mem(32'hC),  1'b1, 32'h14,  32'd3, 32'd0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,   32'h10,  mem(32'h10), 1'b1, 32'h18,  32'd3, 32'd0};
        // redirect at PC 0x10 to 0x100: two bubbles then target
        vecs[9]  = '{1'b1, 1'b1, 32'h100, 32'h0,   NOP,          1'b0, 32'h100, 32'd3, 32'd1};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   32'h0,   NOP,          1'b0, 32'h104, 32'd3, 32'd1};
        vecs[11] = '{1'b1, 1'b0, 32'h0,   32'h100, mem(32'h100), 1'b1, 32'h108, 32'd3, 32'd1};
        vecs[12] = '{1'b1, 1'b0, 32'h0,   32'h104, mem(32'h104), 1'b1, 32'h10C, 32'd3, 32'd1};
        // enter HOLD, then redirect and stall on the same edge
        vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h104, mem(32'h104), 1'b1, 32'h10C, 32'd4, 32'd1};
        vecs[14] = '{1'b0, 1'b1, 32'h200, 32'h0,   NOP,          1'b0, 32'h200, 32'd4, 32'd2};
        vecs[15] = '{1'b1, 1'b0, 32'h0,   32'h0,   NOP,          1'b0, 32'h204, 32'd4, 32'd2};
        vecs[16] = '{1'b1, 1'b0, 32'h0,   32'h200, mem(32'h200), 1'b1, 32'h208, 32'd4, 32'd2};
        vecs[17] = '{1'b1, 1'b0, 32'h0,   32'h204, mem(32'h204), 1'b1, 32'h20C, 32'd4, 32'd2};
        // leave the DUT in HOLD for the mid-stall reset
        vecs[18] = '{1'b0, 1'b0, 32'h0,   32'h204, mem(32'h204), 1'b1, 32'h20C, 32'd5, 32'd2};

        wrap_exp_pc[0] = 32'hFFFF_FFF8;
        wrap_exp_pc[1] = 32'hFFFF_FFFC;
        wrap_exp_pc[2] = 32'h0000_0000;
        wrap_exp_pc[3] = 32'h0000_0004;

        arst_n           = 1'b0;
        pc_write         = 1'b1;
        if_id_write      = 1'b1;
        branch_taken     = 1'b0;
        branch_target    = 32'h0;
        w2_pc_write      = 1'b1;
        w2_branch_taken  = 1'b0;
        w2_branch_target = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset pc_IF_ID",    pc_IF_ID,    32'h0);
        check("reset instr_IF_ID", instr_IF_ID, NOP);
        check("reset valid_IF_ID", {31'h0, valid_IF_ID}, 32'h0);
        check("reset imem_addr",   imem_addr,   32'h0);
        check("reset wrap imem_addr", w2_imem_addr, WRAP_PC);
`ifdef STALL_COUNTER_EN
        check("reset stall_cnt", stall_cnt, 32'h0);
        check("reset flush_cnt", flush_cnt, 32'h0);
`endif
        arst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            v             = vecs[i];
            pc_write      = v.pw;
            if_id_write   = v.pw;
            branch_taken  = v.br;
            branch_target = v.tgt;
            sb_q.push_back(v);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("edge%0d pc_IF_ID", i + 1),    pc_IF_ID,    e.exp_pc);
            check($sformatf("edge%0d instr_IF_ID", i + 1), instr_IF_ID, e.exp_instr);
            check($sformatf("edge%0d valid_IF_ID", i + 1), {31'h0, valid_IF_ID}, {31'h0, e.exp_valid});
            check($sformatf("edge%0d imem_addr", i + 1),   imem_addr,   e.exp_addr);
`ifdef STALL_COUNTER_EN
            check($sformatf("edge%0d stall_cnt", i + 1), stall_cnt, e.exp_stall);
            check($sformatf("edge%0d flush_cnt", i + 1), flush_cnt, e.exp_flush);
`endif
            if (i >= 1 && i <= 4) begin
                check($sformatf("wrap edge%0d pc_IF_ID", i + 1), w2_pc_IF_ID, wrap_exp_pc[i - 1]);
                check($sformatf("wrap edge%0d instr_IF_ID", i + 1), w2_instr_IF_ID, mem(wrap_exp_pc[i - 1]));
            end
        end
        branch_taken = 1'b0;

        // Asynchronous reset in the middle of HOLD: outputs return at once.
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("hold reset pc_IF_ID",    pc_IF_ID,    32'h0);
        check("hold reset instr_IF_ID", instr_IF_ID, NOP);
        check("hold reset valid_IF_ID", {31'h0, valid_IF_ID}, 32'h0);
        check("hold reset imem_addr",   imem_addr,   32'h0);
`ifdef STALL_COUNTER_EN
        check("hold reset stall_cnt", stall_cnt, 32'h0);
        check("hold reset flush_cnt", flush_cnt, 32'h0);
`endif
        #2;
        arst_n = 1'b1;

        // A stall in BOOT changes nothing but the stall counter.
        @(posedge clk);
        #1;
        check("boot stall valid_IF_ID", {31'h0, valid_IF_ID}, 32'h0);
        check("boot stall imem_addr",   imem_addr, 32'h0);
`ifdef STALL_COUNTER_EN
        check("boot stall stall_cnt", stall_cnt, 32'h1);
`endif
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        @(posedge clk);
        #1;
        check("restart edge1 valid_IF_ID", {31'h0, valid_IF_ID}, 32'h0);
        check("restart edge1 imem_addr",   imem_addr, 32'h4);
        @(posedge clk);
        #1;
        check("restart edge2 pc_IF_ID",    pc_IF_ID,    32'h0);
        check("restart edge2 instr_IF_ID", instr_IF_ID, mem(32'h0));
        check("restart edge2 valid_IF_ID", {31'h0, valid_IF_ID}, 32'h1);
        @(posedge clk);
        #1;
        check("restart edge3 pc_IF_ID", pc_IF_ID, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_instruction_fetch_stage
